// File: rtl/line_buffer_responder.sv
// Single-line (256-bit) write-back buffer between a 32-bit CPU port and a
// 64-bit burst memory port: hits answer in one cycle, misses write back then fill.
module line_buffer_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_mbe,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic [31:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [63:0] pmem_wdata,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_WRITEBACK, S_FILL} state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  state_t        r_state, w_next;
  logic [1:0]    r_k;
  logic [255:0]  r_data;
  logic [26:0]   r_tag;
  logic          r_valid, r_dirty;
  logic [31:0]   r_rdata;
  logic [26:0]   r_req_tag;
  logic [2:0]    r_req_word;
  logic          r_req_wr;
  logic [31:0]   r_req_wdata;
  logic [3:0]    r_req_mbe;

  logic          w_req, w_hit, w_last, w_unused;
  logic [31:0]   w_cur_word, w_fill_word;
  logic [255:0]  w_fill_line;

  assign w_req      = mem_read | mem_write;
  assign w_hit      = r_valid && (r_tag == mem_address[31:5]);
  assign w_last     = pmem_resp && (r_k == 2'd3);
  assign w_cur_word = r_data[{mem_address[4:2], 5'd0} +: 32];
  assign w_unused   = ^mem_address[1:0];
  assign mem_rdata  = r_rdata;

  // Line image including the beat arriving this cycle, so the final fill
  // beat can be forwarded/merged in the same edge that installs the line.
  always_comb begin
    w_fill_line = r_data;
    w_fill_line[{r_k, 6'd0} +: 64] = pmem_rdata;
  end
  assign w_fill_word = w_fill_line[{r_req_word, 5'd0} +: 32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = 64'd0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit)                    w_next = S_RESP;
          else if (r_valid && r_dirty)  w_next = S_WRITEBACK;
          else                          w_next = S_FILL;
        end
      end
      S_RESP: begin
        mem_resp = 1'b1;
        w_next   = S_IDLE;
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag, 5'd0};
        pmem_wdata   = r_data[{r_k, 6'd0} +: 64];
        if (w_last) w_next = S_FILL;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {r_req_tag, 5'd0};
        if (w_last) w_next = w_req ? S_RESP : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k     <= 2'd0;
      r_valid <= 1'b0;
      r_dirty <= 1'b0;
      r_tag   <= 27'd0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_hit) begin
            if (mem_write) r_dirty <= 1'b1;
            else           r_rdata <= w_cur_word;
          end
        end
        S_WRITEBACK: begin
          if (pmem_resp) begin
            r_k <= r_k + 2'd1;
            if (w_last) r_dirty <= 1'b0;
          end
        end
        S_FILL: begin
          if (pmem_resp) begin
            r_k <= r_k + 2'd1;
            if (w_last) begin
              r_valid <= 1'b1;
              r_tag   <= r_req_tag;
              r_dirty <= w_req && r_req_wr;
              if (w_req && !r_req_wr) r_rdata <= w_fill_word;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage and captured request carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          r_req_tag   <= mem_address[31:5];
          r_req_word  <= mem_address[4:2];
          r_req_wr    <= mem_write;
          r_req_wdata <= mem_wdata;
          r_req_mbe   <= mem_mbe;
          if (w_hit && mem_write)
            r_data[{mem_address[4:2], 5'd0} +: 32] <= merge_bytes(w_cur_word, mem_wdata, mem_mbe);
        end
      end
      S_FILL: begin
        if (pmem_resp) begin
          r_data <= w_fill_line;
          if (w_last && w_req && r_req_wr)
            r_data[{r_req_word, 5'd0} +: 32] <= merge_bytes(w_fill_word, r_req_wdata, r_req_mbe);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_buffer_responder.sv
// Directed bench: a word-level line model plus a random-latency burst memory
// are compared against line_buffer_responder every meaningful cycle.
module tb_line_buffer_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_address = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_mbe = '0;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic [31:0] pmem_address;
  logic        pmem_read, pmem_write;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  line_buffer_responder dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_mbe(mem_mbe),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [31:0] addr; } burst_t;
  burst_t      exp_bursts[$];
  burst_t      act_bursts[$];
  int          act_beats[$];
  logic [63:0] pmem_mem [int];

  int n_vec = 0, n_err = 0;

  logic [31:0] m_line [8];
  logic [26:0] m_tag = '0;
  logic        m_valid = 1'b0, m_dirty = 1'b0;

  logic        exp_pending = 1'b0, exp_is_read = 1'b0;
  logic [31:0] exp_rdata = '0;
  int          resp_seen = 0;
  logic        stray_en = 1'b0, hold_at2 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pm_rd(input int idx);
    logic [31:0] i32;
    i32 = idx[31:0];
    if (pmem_mem.exists(idx)) return pmem_mem[idx];
    return {i32, 32'hC0DE_0000 ^ i32};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Burst memory: random 0-5 cycle gap before every beat, logs each burst.
  initial begin
    logic        s_active, s_kind;
    int          s_beat, s_wait, idx;
    logic [31:0] s_addr;
    burst_t      b;
    s_active = 1'b0; s_kind = 1'b0; s_beat = 0; s_wait = 0; s_addr = '0;
    pmem_resp = 1'b0; pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    forever begin
      @(posedge clk); #1;
      pmem_resp  = 1'b0;
      pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      if (!rst) begin
        s_active = 1'b0;
      end else if (pmem_read || pmem_write) begin
        if (!s_active || s_kind != pmem_write) begin
          b.wr = pmem_write; b.addr = pmem_address;
          act_bursts.push_back(b); act_beats.push_back(0);
          s_active = 1'b1; s_kind = pmem_write; s_addr = pmem_address;
          s_beat = 0; s_wait = $urandom_range(0, 5);
        end
        if (!(hold_at2 && s_beat == 2)) begin
          if (s_wait == 0) begin
            pmem_resp = 1'b1;
            idx = int'(s_addr >> 3) + s_beat;
            if (s_kind) pmem_mem[idx] = pmem_wdata;
            else        pmem_rdata = pm_rd(idx);
            act_beats[act_beats.size()-1] += 1;
            s_beat++;
            s_wait = $urandom_range(0, 5);
            if (s_beat == 4) s_active = 1'b0;
          end else begin
            s_wait--;
          end
        end
      end else begin
        s_active = 1'b0;
        if (stray_en) pmem_resp = 1'b1;
      end
    end
  end

  // Compare process: burst address/direction against the model's expected
  // burst list, and every mem_resp against the model's pending answer.
  initial begin
    int bi;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pmem_read || pmem_write) begin
          bi = act_bursts.size() - 1;
          chk("pmem_rw_exclusive", 64'(pmem_read & pmem_write), 64'd0);
          if (bi >= 0 && bi < exp_bursts.size()) begin
            chk("pmem_address", 64'(pmem_address), 64'(exp_bursts[bi].addr));
            chk("pmem_dir", 64'(pmem_write), 64'(exp_bursts[bi].wr));
          end else begin
            chk("unexpected_burst", 64'(bi), 64'(exp_bursts.size() - 1));
          end
        end
        if (mem_resp) begin
          chk("resp_expected", 64'(exp_pending), 64'd1);
          if (exp_pending && exp_is_read) chk("mem_rdata", 64'(mem_rdata), 64'(exp_rdata));
          exp_pending = 1'b0;
          resp_seen++;
        end
      end
    end
  end

  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input string name);
    logic        hit, wb, got;
    int          w, waits, nbase, obase;
    logic [31:0] newl [8];
    logic [31:0] oldl [8];
    logic [63:0] bt;
    burst_t      b;
    w     = int'(addr[4:2]);
    hit   = m_valid && (m_tag == addr[31:5]);
    wb    = !hit && m_valid && m_dirty;
    nbase = int'({addr[31:5], 5'd0} >> 3);
    obase = int'({m_tag, 5'd0} >> 3);
    exp_bursts.delete(); act_bursts.delete(); act_beats.delete();
    if (wb) begin b.wr = 1'b1; b.addr = {m_tag, 5'd0}; exp_bursts.push_back(b); end
    if (!hit) begin
      b.wr = 1'b0; b.addr = {addr[31:5], 5'd0}; exp_bursts.push_back(b);
      for (int i = 0; i < 8; i++) begin
        bt = pm_rd(nbase + i/2);
        newl[i] = (i % 2 == 1) ? bt[63:32] : bt[31:0];
      end
    end else begin
      newl = m_line;
    end
    oldl = m_line;
    @(posedge clk); #2;
    exp_rdata = newl[w]; exp_is_read = !wr; exp_pending = 1'b1; resp_seen = 0;
    mem_address = addr; mem_read = rd; mem_write = wr; mem_wdata = wd; mem_mbe = be;
    waits = 0;
    do begin @(negedge clk); waits++; end while (!mem_resp && waits < 200);
    got = mem_resp;
    #1 mem_read = 1'b0; mem_write = 1'b0;
    chk({name, "_resp"}, 64'(got), 64'd1);
    if (hit) chk({name, "_hit_latency"}, 64'(waits), 64'd2);
    repeat (2) @(negedge clk);
    chk({name, "_resp_count"}, 64'(resp_seen), 64'd1);
    chk({name, "_bursts"}, 64'(act_bursts.size()), 64'(exp_bursts.size()));
    for (int i = 0; i < act_beats.size(); i++) chk({name, "_beats"}, 64'(act_beats[i]), 64'd4);
    if (wb)
      for (int k = 0; k < 4; k++)
        chk({name, "_wb_data"}, pm_rd(obase + k), {oldl[2*k+1], oldl[2*k]});
    m_line = newl;
    if (!hit) begin m_tag = addr[31:5]; m_valid = 1'b1; m_dirty = 1'b0; end
    if (wr) begin m_line[w] = merge(m_line[w], wd, be); m_dirty = 1'b1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    for (int k = 0; k < 4; k++) m_line[2*k] = '0;
    for (int k = 0; k < 4; k++) m_line[2*k+1] = '0;
    pmem_mem[512] = 64'h1111_1111_2222_2222;
    pmem_mem[513] = 64'h2222_2222_3333_3333;
    pmem_mem[514] = 64'h3333_3333_4444_4444;
    pmem_mem[515] = 64'h4444_4444_5555_5555;

    repeat (2) @(negedge clk);
    chk("rst_mem_resp", 64'(mem_resp), 64'd0);
    chk("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_pmem_read", 64'(pmem_read), 64'd0);
    chk("rst_pmem_write", 64'(pmem_write), 64'd0);
    chk("rst_pmem_address", 64'(pmem_address), 64'd0);
    chk("rst_pmem_wdata", pmem_wdata, 64'd0);
    rst = 1'b1;

    cpu_op(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0, "cold_read");
    chk("cold_read_lit", 64'(mem_rdata), 64'h1111_1111);
    cpu_op(1'b0, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 4'b0011, "hit_write");
    cpu_op(1'b1, 1'b0, 32'h0000_1008, 32'h0, 4'h0, "hit_read");
    chk("hit_read_lit", 64'(mem_rdata), 64'h3333_BEEF);
    cpu_op(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, "dirty_miss");
    chk("wb_beat1_lit", pm_rd(513), 64'h2222_2222_3333_BEEF);

    stray_en = 1'b1;
    repeat (3) @(negedge clk);
    stray_en = 1'b0;
    chk("stray_no_burst", 64'(pmem_read | pmem_write), 64'd0);
    cpu_op(1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'h0, "after_stray");

    cpu_op(1'b0, 1'b1, 32'h0000_4010, 32'h1234_5678, 4'b1100, "write_miss");
    chk("write_miss_model_lit", 64'(m_line[4]), 64'h1234_0802);
    cpu_op(1'b1, 1'b0, 32'h0000_4010, 32'h0, 4'h0, "write_miss_read");
    cpu_op(1'b1, 1'b1, 32'h0000_4014, 32'hCAFE_F00D, 4'b1111, "rd_wr_both");
    cpu_op(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, "wb_after_both");
    chk("both_wb_lit", pm_rd(32'h4010 >> 3), 64'hCAFE_F00D_1234_0802);

    // Reset in the middle of a fill, after its second beat.
    exp_bursts.delete(); act_bursts.delete(); act_beats.delete();
    exp_bursts.push_back('{wr: 1'b0, addr: 32'h0000_3000});
    exp_pending = 1'b0; resp_seen = 0; hold_at2 = 1'b1;
    @(posedge clk); #2;
    mem_address = 32'h0000_3000; mem_read = 1'b1; mem_write = 1'b0;
    waits = 0;
    do begin @(negedge clk); waits++; end
    while (!(act_beats.size() == 1 && act_beats[0] == 2) && waits < 200);
    chk("rst_fill_two_beats", 64'(act_beats.size() == 1 && act_beats[0] == 2), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_pmem_read", 64'(pmem_read), 64'd0);
    chk("midrst_pmem_address", 64'(pmem_address), 64'd0);
    chk("midrst_mem_resp", 64'(mem_resp), 64'd0);
    chk("midrst_mem_rdata", 64'(mem_rdata), 64'd0);
    repeat (2) @(negedge clk);
    mem_read = 1'b0; rst = 1'b1; hold_at2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_resp", 64'(resp_seen), 64'd0);
    m_valid = 1'b0; m_dirty = 1'b0;

    cpu_op(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0, "refill_after_rst");
    cpu_op(1'b1, 1'b0, 32'h0000_301C, 32'h0, 4'h0, "refill_hit_last_word");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_buffer_responder.md
LINE_BUFFER_RESPONDER -- requirements
Module: line_buffer_responder

Interface
REQ-001 SHALL have no parameters; line = 256 bits = 4 beats x 64 bits = 8 words x 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 mem_address  input  32  CPU-side byte address; tag = [31:5], word = [4:2], [1:0] ignored.
REQ-005 mem_read  input  1  CPU read request; held until mem_resp.
REQ-006 mem_write  input  1  CPU write request; held until mem_resp.
REQ-007 mem_wdata  input  32  CPU write data.
REQ-008 mem_mbe  input  4  byte enables; bit i enables mem_wdata[8i+7:8i].
REQ-009 mem_resp  output  1  single-cycle completion pulse.
REQ-010 mem_rdata  output  32  read data; valid only while mem_resp=1.
REQ-011 pmem_address  output  32  line address {tag,5'b0} for the burst.
REQ-012 pmem_read  output  1  line fill request; held for the whole burst.
REQ-013 pmem_write  output  1  line writeback request; held for the whole burst.
REQ-014 pmem_wdata  output  64  writeback beat data.
REQ-015 pmem_rdata  input  64  fill beat data; valid when pmem_resp=1.
REQ-016 pmem_resp  input  1  one pulse per accepted/returned beat; 4 pulses per burst.

Function
REQ-017 SHALL hold one line: data[255:0], tag[26:0], valid, dirty.
REQ-018 States SHALL be IDLE, RESP, WRITEBACK, FILL.
REQ-019 IDLE: request = mem_read|mem_write; mem_read and mem_write both high SHALL be treated as a write.
REQ-020 IDLE, request, hit (valid && tag match): go RESP; read latches word into mem_rdata; write merges enabled bytes into word, sets dirty.
REQ-021 RESP: mem_resp=1 for exactly one cycle, then IDLE; hit latency = 1 cycle after request sampled; one access per 2 cycles max.
REQ-022 IDLE, request, miss, dirty=1: go WRITEBACK; miss with dirty=0 (or valid=0): go FILL.
REQ-023 WRITEBACK: pmem_write=1, pmem_address={stored tag,5'b0}, pmem_wdata=data[64k+63:64k] for beat counter k; k increments on pmem_resp; after 4th pulse clear dirty, k=0, go FILL.
REQ-024 FILL: pmem_read=1, pmem_address={request tag,5'b0}; on each pmem_resp write pmem_rdata into beat k, k++; after 4th pulse set valid=1, dirty=0, tag=request tag, then perform the hit action of REQ-020 and go RESP.
REQ-025 Beat counter SHALL be 2 bits, start at 0 for every burst, wrap 3->0 on the final beat.
REQ-026 pmem_address, pmem_read, pmem_write SHALL stay constant from first cycle of a burst until the cycle after its 4th pmem_resp; pmem_read and pmem_write never both high.
REQ-027 pmem_resp outside WRITEBACK/FILL SHALL be ignored.
REQ-028 Request dropped during WRITEBACK/FILL: burst SHALL complete, line updated, return to IDLE with no mem_resp.
REQ-029 mem_rdata SHALL hold last value outside RESP; mem_resp never high outside RESP.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, k=0, valid=0, dirty=0, mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, including mid-burst (burst abandoned, no completion).
REQ-031 Line data SHALL not require reset.

Verification
REQ-032 Cold read 0x0000_1004, pmem beats 0x1111..,0x2222..,0x3333..,0x4444.. -> one FILL to 0x0000_1000, no writeback, mem_resp once, mem_rdata = upper 32 bits of beat 0.
REQ-033 Then write 0x0000_1008 data 0xDEADBEEF mbe 4'b0011 -> mem_resp 1 cycle after sample, no pmem activity; read 0x0000_1008 -> 0x3333BEEF.
REQ-034 Then read 0x0000_2000 -> WRITEBACK of 4 beats to 0x0000_1000 (beat 1 = 0x2222_2222_3333_BEEF), then FILL from 0x0000_2000, then mem_resp.
REQ-035 pmem_resp delayed 0-5 random cycles per beat -> pmem_address/pmem_read stable throughout, exactly 4 beats consumed, data correct.
REQ-036 rst asserted after 2nd FILL beat -> pmem_read=0 same cycle, no mem_resp; next read of same address refills from beat 0.
REQ-037 mem_read and mem_write both high on a hit -> treated as write, dirty set, single mem_resp.
